// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, keeps at most one imem request
// outstanding, and holds the IF/ID register backed by a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    localparam int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [6:0]      id_op,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } slot_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    slot_t           buf_q, buf_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc4_q, id_pc4_d;
    logic            imem_req_q, imem_req_d;

    logic            accept;
    logic            id_load;
    slot_t           load_slot;
    logic            unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // Next-state, PC, buffer and IF/ID update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        id_load   = 1'b0;
        load_slot = '{instr: imem_rdata, pc: pc_q};
        accept    = !id_valid_q || !stall;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack) begin
                    pc_d = pc_q + XLEN'(4);
                    if (accept) begin
                        id_load = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        buf_d   = '{instr: imem_rdata, pc: pc_q};
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    id_load   = 1'b1;
                    load_slot = buf_q;
                    state_d   = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush overrides everything; an issued-but-unanswered request must drain in DROP
        if (redirect) begin
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            id_load = 1'b0;
            if ((state_q == S_REQ) ||
                (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_ack)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end

        id_valid_d = id_load || (id_valid_q && stall && !redirect);
        if (id_load) begin
            id_instr_d = load_slot.instr;
            id_pc_d    = load_slot.pc;
            id_pc4_d   = load_slot.pc + XLEN'(4);
        end else begin
            id_instr_d = id_valid_d ? id_instr_q : NOP_INSTR;
            id_pc_d    = id_pc_q;
            id_pc4_d   = id_pc4_q;
        end

        imem_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            buf_q      <= '{instr: NOP_INSTR, pc: RESET_PC};
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= RESET_PC;
            id_pc4_q   <= RESET_PC + XLEN'(4);
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;
    assign id_op     = id_instr_q[6:0];
    assign id_funct3 = id_instr_q[14:12];
    assign id_funct7 = id_instr_q[31:25];

endmodule
